polar_to_cartesian_pipe: RTL and testbench

Pipelined, parametrised polar-to-cartesian converter for the radar display path. It accepts a radius and an angle index in 15° steps over the full 0–345° circle. It produces signed, rounded x/y coordinates through a 3-stage valid/ready pipeline with per-stage bubble collapse. Invalid angle indices are flagged rather than converted. It sits between the sensor-sample unpacker and the display plotter, and replaces the earlier combinational semicircle-only converter.

---
 rtl/polar_to_cartesian_pipe.sv | 155 +++++++++++++++
 tb/tb_polar_to_cartesian_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_to_cartesian_pipe.sv
`default_nettype none
// ============================================================================
// Module   : polar_to_cartesian_pipe
// Purpose  : 3-stage valid/ready polar (radius, 15-degree index) to signed x/y
// Revision : 1.0
// ============================================================================
module polar_to_cartesian_pipe #(
  parameter int R_WIDTH     = 8,
  parameter int ANGLE_WIDTH = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ANGLE_WIDTH-1:0]   in_angle,
  input  logic [R_WIDTH-1:0]       in_radius,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [R_WIDTH:0]  out_x,
  output logic signed [R_WIDTH:0]  out_y,
  output logic                     out_error
);

  localparam int P_WIDTH = R_WIDTH + 11;
  localparam logic [ANGLE_WIDTH-1:0] MAX_IDX = ANGLE_WIDTH'(23);

  function automatic logic [10:0] sine_q10(input logic [2:0] k);
    case (k)
      3'd0:    sine_q10 = 11'd0;
      3'd1:    sine_q10 = 11'd265;
      3'd2:    sine_q10 = 11'd512;
      3'd3:    sine_q10 = 11'd724;
      3'd4:    sine_q10 = 11'd887;
      3'd5:    sine_q10 = 11'd989;
      3'd6:    sine_q10 = 11'd1024;
      default: sine_q10 = 11'd0;
    endcase
  endfunction

  // Angle decode: quadrant selects which table entry feeds each axis and its sign
  logic [4:0]  idx5;
  logic [1:0]  quad;
  logic [2:0]  k;
  logic [2:0]  kc;
  logic        angle_err;
  logic [10:0] dec_tx;
  logic [10:0] dec_ty;
  logic        dec_sx;
  logic        dec_sy;

  always_comb begin
    angle_err = in_angle > MAX_IDX;
    idx5      = in_angle[4:0];
    quad      = 2'(idx5 / 5'd6);
    k         = 3'(idx5 % 5'd6);
    kc        = 3'd6 - k;
    dec_tx    = '0;
    dec_ty    = '0;
    dec_sx    = 1'b0;
    dec_sy    = 1'b0;
    if (!angle_err) begin
      case (quad)
        2'd0: begin dec_tx = sine_q10(kc); dec_ty = sine_q10(k); end
        2'd1: begin dec_tx = sine_q10(k);  dec_ty = sine_q10(kc); dec_sx = 1'b1; end
        2'd2: begin dec_tx = sine_q10(kc); dec_ty = sine_q10(k);  dec_sx = 1'b1; dec_sy = 1'b1; end
        default: begin dec_tx = sine_q10(k); dec_ty = sine_q10(kc); dec_sy = 1'b1; end
      endcase
    end
  end

  logic               v1, v2, v3;
  logic               load1, load2, load3;
  logic [R_WIDTH-1:0] r1;
  logic [10:0]        tx1, ty1;
  logic               sx1, sy1, err1;
  logic [P_WIDTH-1:0] px2, py2;
  logic               sx2, sy2, err2;

  assign load3     = !v3 || out_ready;
  assign load2     = !v2 || load3;
  assign load1     = !v1 || load2;
  assign in_ready  = load1;
  assign out_valid = v3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      r1   <= '0;
      tx1  <= '0;
      ty1  <= '0;
      sx1  <= 1'b0;
      sy1  <= 1'b0;
      err1 <= 1'b0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        r1   <= in_radius;
        tx1  <= dec_tx;
        ty1  <= dec_ty;
        sx1  <= dec_sx;
        sy1  <= dec_sy;
        err1 <= angle_err;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v2   <= 1'b0;
      px2  <= '0;
      py2  <= '0;
      sx2  <= 1'b0;
      sy2  <= 1'b0;
      err2 <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        px2  <= P_WIDTH'(r1) * P_WIDTH'(tx1);
        py2  <= P_WIDTH'(r1) * P_WIDTH'(ty1);
        sx2  <= sx1;
        sy2  <= sy1;
        err2 <= err1;
      end
    end
  end

  // Round half up on the magnitude, then apply sign so rounding is symmetric
  logic [P_WIDTH-1:0] rnd_x, rnd_y;
  logic [R_WIDTH:0]   mag_x, mag_y;

  always_comb begin
    rnd_x = px2 + P_WIDTH'(512);
    rnd_y = py2 + P_WIDTH'(512);
    mag_x = rnd_x[P_WIDTH-1:10];
    mag_y = rnd_y[P_WIDTH-1:10];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v3        <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_error <= 1'b0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        out_x     <= sx2 ? -mag_x : mag_x;
        out_y     <= sy2 ? -mag_y : mag_y;
        out_error <= err2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_polar_to_cartesian_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_polar_to_cartesian_pipe
// Purpose  : directed and randomised-handshake checks of polar_to_cartesian_pipe
// Revision : 1.0
// ============================================================================
module tb_polar_to_cartesian_pipe;

  localparam int RW = 8;
  localparam int AW = 5;
  localparam int TBL [7] = '{0, 265, 512, 724, 887, 989, 1024};

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic [AW-1:0]       in_angle = '0;
  logic [RW-1:0]       in_radius = '0;
  logic                in_ready;
  logic                out_valid;
  logic                out_error;
  logic signed [RW:0]  out_x;
  logic signed [RW:0]  out_y;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int outs = 0;
  logic accepted = 1'b0;

  typedef struct { int x; int y; int e; } sample_t;
  sample_t exp_q[$];
  sample_t pend;

  always #5 clock = ~clock;

  polar_to_cartesian_pipe #(.R_WIDTH(RW), .ANGLE_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_angle(in_angle), .in_radius(in_radius),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_error(out_error)
  );

  task automatic check(input string tag, input integer obs, input integer expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Full-circle sine in 15-degree steps; cosine is the same curve shifted 90 degrees
  function automatic int sin_q10(input int j);
    int h, t;
    h = j % 12;
    t = TBL[(h <= 6) ? h : 12 - h];
    return (j >= 12) ? -t : t;
  endfunction

  function automatic int scale(input int r, input int s);
    int m;
    m = (r * ((s < 0) ? -s : s) + 512) >>> 10;
    return (s < 0) ? -m : m;
  endfunction

  task automatic model(input int a, input int r, output int x, output int y, output int e);
    if (a > 23) begin x = 0; y = 0; e = 1; end
    else begin
      x = scale(r, sin_q10((a + 6) % 24));
      y = scale(r, sin_q10(a));
      e = 0;
    end
  endtask

  // One clock: observe handshakes mid-cycle, then advance to just after the edge
  task automatic cycle();
    sample_t s;
    @(negedge clock);
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      outs++;
      if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        s = exp_q.pop_front();
        check("out_x", $signed(out_x), s.x);
        check("out_y", $signed(out_y), s.y);
        check("out_error", out_error, s.e);
      end
    end
    if (accepted) exp_q.push_back(pend);
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int a, input int r, input int x, input int y, input int e);
    in_angle  = AW'(a);
    in_radius = RW'(r);
    pend      = '{x, y, e};
    in_valid  = 1'b1;
  endtask

  task automatic send(input int a, input int r, input int x, input int y, input int e);
    int n;
    set_in(a, r, x, y, e);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 50);
    if (!accepted) check("accept_timeout", accepted, 1);
  endtask

  task automatic model_send(input int a, input int r);
    int x, y, e;
    model(a, r, x, y, e);
    send(a, r, x, y, e);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int c0, o0, sent, guard, a, r, ex, ey, ee;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", $signed(out_x), 0);
    check("rst_out_y", $signed(out_y), 0);
    check("rst_out_error", out_error, 0);
    reset_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    // Latency: three edges from capture to presentation
    out_ready = 1'b1;
    send(1, 100, 97, 26, 0);
    in_valid = 1'b0;
    check("lat_edge1_valid", out_valid, 0);
    cycle();
    check("lat_edge2_valid", out_valid, 0);
    cycle();
    check("lat_edge3_valid", out_valid, 1);
    check("lat_x", $signed(out_x), 97);
    check("lat_y", $signed(out_y), 26);
    drain();

    // Directed points
    send(11, 100, -97, 26, 0);
    send(18, 255, 0, -255, 0);
    send(0, 255, 255, 0, 0);
    send(12, 0, 0, 0, 0);
    send(3, 200, 141, 141, 0);
    send(21, 200, 141, -141, 0);
    drain();

    // Back-to-back sweep at one sample per cycle
    c0 = cyc;
    o0 = outs;
    for (int i = 0; i < 24; i++) model_send(i, 200);
    check("sweep_cycles", cyc - c0, 24);
    check("sweep_outs_inflight", outs - o0, 21);
    drain();
    check("sweep_outs_total", outs - o0, 24);

    // Invalid angles keep their slot between valid neighbours
    send(5, 50, 13, 48, 0);
    send(24, 50, 0, 0, 1);
    send(31, 50, 0, 0, 1);
    send(6, 50, 0, 50, 0);
    drain();

    // Backpressure: capacity three, head sample held stable
    out_ready = 1'b0;
    send(2, 100, 87, 50, 0);
    send(7, 100, -26, 97, 0);
    send(24, 50, 0, 0, 1);
    set_in(13, 100, -97, -26, 0);
    #1;
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_x", $signed(out_x), 87);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_in_ready_hold", in_ready, 0);
      check("bp_stable_x", $signed(out_x), 87);
      check("bp_stable_y", $signed(out_y), 50);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    send(13, 100, -97, -26, 0);
    send(23, 100, 97, -26, 0);
    drain();

    // Random handshake pattern against the model
    o0 = outs;
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      a = $urandom_range(31);
      r = $urandom_range(255);
      model(a, r, ex, ey, ee);
      set_in(a, r, ex, ey, ee);
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      cycle();
      if (accepted) sent++;
      guard++;
    end
    check("rand_sent", sent, 1000);
    drain();
    check("rand_outs", outs - o0, 1000);

    // Reset with samples in flight
    out_ready = 1'b0;
    model_send(4, 120);
    model_send(9, 130);
    model_send(15, 140);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_x", $signed(out_x), 0);
    check("mid_rst_y", $signed(out_y), 0);
    check("mid_rst_error", out_error, 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("post_rst_idle", out_valid, 0);
    end
    send(0, 255, 255, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
